// File: rtl/title_overlay_ctrl.sv
// Title / game-over overlay sequencer and sprite pixel generator.
// Define OVERLAY_BLINK_EN to blink the press-enter banner in TITLE_WAIT.
module title_overlay_ctrl #(
  parameter int LOGO_X       = 224,
  parameter int LOGO_Y_END   = 96,
  parameter int GO_X         = 192,
  parameter int GO_Y         = 224,
  parameter int PE_X         = 292,
  parameter int PE_Y         = 320,
  parameter int GO_FRAMES    = 180,
  parameter int BLINK_FRAMES = 32
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_tick,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic         start_key,
  input  logic         game_over,
  output logic [3:0]   galaga_addr,
  input  logic [95:0]  galaga_data,
  output logic [3:0]   go_addr,
  input  logic [127:0] go_data,
  output logic [2:0]   pe_addr,
  input  logic [54:0]  pe_data,
  output logic         overlay_on,
  output logic [1:0]   overlay_color,
  output logic         play_active
);

  localparam int CNT_MAX =
    (GO_FRAMES > BLINK_FRAMES) ? GO_FRAMES : BLINK_FRAMES;
  localparam int CW = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    TITLE_DROP,
    TITLE_WAIT,
    PLAY,
    GAMEOVER
  } state_t;

  state_t        state;
  logic [9:0]    logo_y;
  logic [9:0]    logo_nxt;
  logic [CW-1:0] frame_cnt;

`ifdef OVERLAY_BLINK_EN
  logic blink;
`else
  wire blink = 1'b1;
`endif

  always_comb begin
    logo_nxt = logo_y + 10'd4;
    if (logo_y >= 10'(LOGO_Y_END - 4))
      logo_nxt = 10'(LOGO_Y_END);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= TITLE_DROP;
      logo_y      <= '0;
      frame_cnt   <= '0;
      play_active <= 1'b0;
`ifdef OVERLAY_BLINK_EN
      blink       <= 1'b1;
`endif
    end else begin
      unique case (state)
        TITLE_DROP: begin
          if (frame_tick) begin
            logo_y <= logo_nxt;
            if (logo_nxt == 10'(LOGO_Y_END))
              state <= TITLE_WAIT;
          end
        end
        TITLE_WAIT: begin
          // start_key beats a coincident frame_tick
          if (start_key) begin
            state       <= PLAY;
            play_active <= 1'b1;
            frame_cnt   <= '0;
          end
`ifdef OVERLAY_BLINK_EN
          else if (frame_tick) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
              blink     <= ~blink;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
`endif
        end
        PLAY: begin
          if (game_over) begin
            state       <= GAMEOVER;
            play_active <= 1'b0;
            frame_cnt   <= '0;
          end
        end
        GAMEOVER: begin
          if (frame_tick) begin
            if (frame_cnt == CW'(GO_FRAMES - 1)) begin
              state     <= TITLE_DROP;
              logo_y    <= '0;
              frame_cnt <= '0;
`ifdef OVERLAY_BLINK_EN
              blink     <= 1'b1;
`endif
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        end
        default: state <= TITLE_DROP;
      endcase
    end
  end

  // signed offsets keep pixels left of / above a box from aliasing in
  logic signed [10:0] gdx, gdy, odx, ody, pdx, pdy;
  logic               g_in, o_in, p_in;
  logic [6:0]         gbit, obit;
  logic [5:0]         pbit;
  logic               g_hit, o_hit, p_hit;

  always_comb begin
    gdx = $signed({1'b0, DrawX}) - $signed(11'(LOGO_X));
    gdy = $signed({1'b0, DrawY}) - $signed({1'b0, logo_y});
    odx = $signed({1'b0, DrawX}) - $signed(11'(GO_X));
    ody = $signed({1'b0, DrawY}) - $signed(11'(GO_Y));
    pdx = $signed({1'b0, DrawX}) - $signed(11'(PE_X));
    pdy = $signed({1'b0, DrawY}) - $signed(11'(PE_Y));

    g_in = (gdx >= 11'sd0) && (gdx < 11'sd192) &&
           (gdy >= 11'sd0) && (gdy < 11'sd32);
    o_in = (odx >= 11'sd0) && (odx < 11'sd256) &&
           (ody >= 11'sd0) && (ody < 11'sd32);
    p_in = (pdx >= 11'sd0) && (pdx < 11'sd55) &&
           (pdy >= 11'sd0) && (pdy < 11'sd5);

    gbit = 7'd95 - gdx[7:1];
    obit = 7'd127 - odx[7:1];
    pbit = 6'd54 - pdx[5:0];

    g_hit = g_in && galaga_data[gbit] &&
            (state == TITLE_DROP || state == TITLE_WAIT);
    o_hit = o_in && go_data[obit] && (state == GAMEOVER);
    p_hit = p_in && pe_data[pbit] &&
            (state == TITLE_WAIT) && blink;
  end

  always_comb begin
    galaga_addr = '0;
    go_addr     = '0;
    pe_addr     = '0;
    if (Reset_n) begin
      galaga_addr = gdy[4:1];
      go_addr     = ody[4:1];
      pe_addr     = pdy[2:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      overlay_on    <= 1'b0;
      overlay_color <= 2'd0;
    end else begin
      priority case (1'b1)
        o_hit: begin
          overlay_on    <= 1'b1;
          overlay_color <= 2'd2;
        end
        p_hit: begin
          overlay_on    <= 1'b1;
          overlay_color <= 2'd3;
        end
        g_hit: begin
          overlay_on    <= 1'b1;
          overlay_color <= 2'd1;
        end
        default: begin
          overlay_on    <= 1'b0;
          overlay_color <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_title_overlay_ctrl.sv
// Directed bench for title_overlay_ctrl with simple patterned ROM rows.
// Expectations follow OVERLAY_BLINK_EN the same way the design does.
module tb_title_overlay_ctrl;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         frame_tick;
  logic [9:0]   DrawX, DrawY;
  logic         start_key, game_over;
  logic [3:0]   galaga_addr, go_addr;
  logic [2:0]   pe_addr;
  logic [95:0]  galaga_data;
  logic [127:0] go_data;
  logic [54:0]  pe_data;
  logic         overlay_on;
  logic [1:0]   overlay_color;
  logic         play_active;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  title_overlay_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .DrawX(DrawX), .DrawY(DrawY),
    .start_key(start_key), .game_over(game_over),
    .galaga_addr(galaga_addr), .galaga_data(galaga_data),
    .go_addr(go_addr), .go_data(go_data),
    .pe_addr(pe_addr), .pe_data(pe_data),
    .overlay_on(overlay_on), .overlay_color(overlay_color),
    .play_active(play_active)
  );

  // row r: fixed left byte plus a single marker bit at index r
  function automatic logic [95:0] g_row(input logic [3:0] a);
    g_row = {8'h0F, 88'd0} | (96'd1 << a);
  endfunction
  function automatic logic [127:0] o_row(input logic [3:0] a);
    o_row = {8'hF0, 120'd0} | (128'd1 << a);
  endfunction
  function automatic logic [54:0] p_row(input logic [2:0] a);
    p_row = {1'b1, 54'd0} | (55'd1 << a);
  endfunction

  assign galaga_data = g_row(galaga_addr);
  assign go_data     = o_row(go_addr);
  assign pe_data     = p_row(pe_addr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
    end
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic on, input logic [1:0] col);
    DrawX = 10'(x);
    DrawY = 10'(y);
    cyc(1);
    chk({tag, "_on"}, 32'(overlay_on), 32'(on));
    chk({tag, "_col"}, 32'(overlay_color), 32'(col));
  endtask

  logic blink_lo;

  initial begin
`ifdef OVERLAY_BLINK_EN
    blink_lo = 1'b0;
`else
    blink_lo = 1'b1;
`endif
    Reset_n = 1'b0; frame_tick = 1'b0;
    start_key = 1'b0; game_over = 1'b0;
    DrawX = 10'd232; DrawY = 10'd100;
    cyc(3);
    chk("rst_on", 32'(overlay_on), 32'd0);
    chk("rst_col", 32'(overlay_color), 32'd0);
    chk("rst_play", 32'(play_active), 32'd0);
    chk("rst_gaddr", 32'(galaga_addr), 32'd0);
    chk("rst_paddr", 32'(pe_addr), 32'd0);
    Reset_n = 1'b1;
    cyc(1);

    pix("drop0", 232, 4, 1'b1, 2'd1);
    start_key = 1'b1;
    cyc(3);
    chk("drop_start", 32'(play_active), 32'd0);
    start_key = 1'b0;

    ticks(23);
    pix("drop23", 232, 96, 1'b1, 2'd1);
    pix("drop23_pe", 292, 320, 1'b0, 2'd0);
    ticks(1);

    DrawX = 10'd232; DrawY = 10'd100;
    #1;
    chk("gaddr", 32'(galaga_addr), 32'd2);
    pix("w_bit95", 224, 100, 1'b0, 2'd0);
    pix("w_bit91", 232, 100, 1'b1, 2'd1);
    pix("w_bit2", 410, 100, 1'b1, 2'd1);
    pix("w_bit1", 412, 100, 1'b0, 2'd0);
    pix("w_row0b0", 414, 96, 1'b1, 2'd1);
    pix("w_left", 223, 96, 1'b0, 2'd0);
    pix("w_right", 416, 96, 1'b0, 2'd0);
    pix("pe_b54", 292, 320, 1'b1, 2'd3);
    pix("pe_b53", 293, 320, 1'b0, 2'd0);
    pix("pe_b0", 346, 320, 1'b1, 2'd3);
    pix("pe_out", 347, 320, 1'b0, 2'd0);
    DrawY = 10'd322;
    #1;
    chk("paddr", 32'(pe_addr), 32'd2);

    ticks(32);
    pix("blink32", 292, 320, blink_lo, blink_lo ? 2'd3 : 2'd0);
    ticks(32);
    pix("blink64", 292, 320, 1'b1, 2'd3);

    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    chk("go_ign_play", 32'(play_active), 32'd0);
    pix("go_ign_pe", 292, 320, 1'b1, 2'd3);

    start_key = 1'b1; frame_tick = 1'b1;
    cyc(1);
    start_key = 1'b0; frame_tick = 1'b0;
    chk("play", 32'(play_active), 32'd1);
    pix("play_g", 232, 100, 1'b0, 2'd0);
    pix("play_pe", 292, 320, 1'b0, 2'd0);
    ticks(2);
    pix("play_g2", 232, 100, 1'b0, 2'd0);

    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    chk("gover_play", 32'(play_active), 32'd0);
    DrawX = 10'd192; DrawY = 10'd228;
    #1;
    chk("oaddr", 32'(go_addr), 32'd2);
    pix("go_b127", 192, 228, 1'b1, 2'd2);
    pix("go_b123", 200, 228, 1'b0, 2'd0);
    pix("go_g", 232, 100, 1'b0, 2'd0);

    ticks(179);
    start_key = 1'b1;
    cyc(2);
    start_key = 1'b0;
    chk("go_start_ign", 32'(play_active), 32'd0);
    pix("go_179", 192, 228, 1'b1, 2'd2);
    ticks(1);
    pix("back_drop", 232, 4, 1'b1, 2'd1);
    pix("back_go", 192, 228, 1'b0, 2'd0);
    pix("back_pe", 292, 320, 1'b0, 2'd0);

    ticks(24);
    start_key = 1'b1;
    cyc(1);
    start_key = 1'b0;
    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    ticks(5);
    pix("go2", 192, 228, 1'b1, 2'd2);
    Reset_n = 1'b0;
    cyc(1);
    chk("mid_rst_on", 32'(overlay_on), 32'd0);
    chk("mid_rst_col", 32'(overlay_color), 32'd0);
    chk("mid_rst_play", 32'(play_active), 32'd0);
    chk("mid_rst_oaddr", 32'(go_addr), 32'd0);
    Reset_n = 1'b1;
    pix("post_rst_go", 192, 228, 1'b0, 2'd0);
    pix("post_rst_g", 232, 4, 1'b1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/title_overlay_ctrl.md
Name: title_overlay_ctrl

Overview:
- Consumes the sprite ROMs: galaga logo (16x96), game-over logo (16x128) and press-enter banner (5x55).
- Sequences title, play and game-over screens per frame and generates the ROM row addresses from DrawX/DrawY.
- Produces a registered overlay pixel (on/colour) for the colour mapper.
- Sits between the VGA controller / game FSM and color_mapper.

Parameters:
- LOGO_X, 224: left x of galaga logo (drawn 2x scale, 192x32)
- LOGO_Y_END, 96: final top y of galaga logo after the drop-in
- GO_X, 192: left x of game-over logo (2x scale, 256x32)
- GO_Y, 224: top y of game-over logo
- PE_X, 292: left x of press-enter banner (1x, 55x5)
- PE_Y, 320: top y of press-enter banner
- GO_FRAMES, 180: frames game-over is shown before returning to title
- BLINK_FRAMES, 32: half-period of press-enter blink, in frames

Ports:
- Clk  in  1  system clock (pixel-rate domain)
- Reset_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- start_key  in  1  enter key held (level)
- game_over  in  1  one-cycle pulse from game FSM: player dead
- galaga_addr  out  4  row address to galaga_rom
- galaga_data  in  96  row data from galaga_rom
- go_addr  out  4  row address to gameover_rom
- go_data  in  128  row data from gameover_rom
- pe_addr  out  3  row address to press_start_rom
- pe_data  in  55  row data from press_start_rom
- overlay_on  out  1  overlay pixel opaque
- overlay_color  out  2  0=white, 1=red (galaga), 2=yellow (game over), 3=cyan (press enter)
- play_active  out  1  high in PLAY state

Behaviour:
- States: TITLE_DROP, TITLE_WAIT, PLAY, GAMEOVER. Reset: TITLE_DROP; logo_y=0; frame_cnt=0; blink=1; overlay_on=0; overlay_color=0; play_active=0; all addr=0.
- TITLE_DROP: each frame_tick logo_y += 4, saturating at LOGO_Y_END. logo_y==LOGO_Y_END at a frame_tick -> TITLE_WAIT.
- start_key is ignored in TITLE_DROP.
- TITLE_WAIT: frame_cnt counts ticks; when frame_cnt==BLINK_FRAMES-1, toggle blink and clear frame_cnt. start_key=1 -> PLAY next cycle; this also clears frame_cnt.
- PLAY: no overlay; play_active=1. game_over -> GAMEOVER and clear frame_cnt.
- GAMEOVER: frame_cnt increments per tick. frame_cnt==GO_FRAMES-1 at a tick -> TITLE_DROP with logo_y=0 and blink=1.
- game_over outside PLAY is ignored. start_key in GAMEOVER is ignored.
- Addresses (combinational from DrawX/DrawY):
  - galaga_addr=(DrawY-logo_y)>>1 (4 LSBs)
  - go_addr=(DrawY-GO_Y)>>1
  - pe_addr=DrawY-PE_Y (3 bits); valid only for rows 0..4.
- Hit test per logo: DrawX/DrawY inside its box. Bit index = WIDTH-1-((DrawX-X0)>>scale). MSB is the leftmost pixel. Use 11-bit signed subtraction so pixels left of or above a box never alias.
- Visibility:
  - galaga: TITLE_DROP and TITLE_WAIT.
  - press-enter: TITLE_WAIT with blink=1.
  - game-over: GAMEOVER only.
- Priority when boxes overlap: game-over > press-enter > galaga.
- Output register: overlay_on/overlay_color are registered, latency exactly 1 Clk from DrawX/DrawY. Outside every box, or with the bit =0: overlay_on=0 and colour 0.
- frame_tick coincident with start_key in TITLE_WAIT: transition wins; the blink counter does not update.
- Reset_n low mid-frame: returns to TITLE_DROP on the next edge; overlay_on=0 on that edge.

Optional Feature:
- OVERLAY_BLINK_EN defined: press-enter blinks as above.
- Undefined: blink is held at 1, the blink counter logic is removed, and the banner is shown steadily throughout TITLE_WAIT. All other behaviour is unchanged.

Test Plan:
- Reset, then 24 frame_ticks -> logo_y=96, state TITLE_WAIT; DrawX=224,DrawY=100 (row 2, bit 95=0) -> overlay_on=0 one cycle later; DrawX=232,DrawY=100 (bit 91=1) -> overlay_on=1, color=1.
- TITLE_WAIT, 32 ticks -> blink=0, and pixel DrawX=292,DrawY=320 reads 0; after 32 more ticks the same pixel reads overlay_on=1, color=3. With macro undefined: 1 throughout.
- start_key=1 during TITLE_DROP -> ignored; in TITLE_WAIT -> play_active=1 next cycle, overlay_on=0 for whole frame.
- game_over pulse in PLAY -> GAMEOVER; DrawX=192,DrawY=228 -> on, color=2. After 180 ticks -> TITLE_DROP, logo_y=0.
- DrawX=223, DrawY=96 and DrawX=416 -> overlay_on=0 (box edges). game_over pulse in TITLE_WAIT -> no state change.
- Reset_n=0 mid-GAMEOVER -> next edge: state TITLE_DROP, all outputs at reset values.
